// File: rtl/img_job_ctrl_if.sv
// Register-bus interface between the PS register master and the image job sequencer.
// The master drives strobes, address and write data; the slave returns registered read data.
interface img_job_ctrl_if;
    logic        reg_wr;
    logic        reg_rd;
    logic [3:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic [31:0] reg_rdata;
    logic        reg_rvalid;

    modport master (
        output reg_wr,
        output reg_rd,
        output reg_addr,
        output reg_wdata,
        input  reg_rdata,
        input  reg_rvalid
    );

    modport slave (
        input  reg_wr,
        input  reg_rd,
        input  reg_addr,
        input  reg_wdata,
        output reg_rdata,
        output reg_rvalid
    );
endinterface

// File: rtl/img_job_ctrl.sv
// Job sequencer for one BRAM image engine: launches a job on a START write, bounds it with a
// cycle timeout, keeps sticky status and a completed-job count, and resets a hung engine.
module img_job_ctrl #(
    parameter int unsigned TO_W    = 16,
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned RST_CYC = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    img_job_ctrl_if.slave bus,
    output logic          eng_start,
    input  logic          eng_done,
    output logic          eng_rst_n,
    output logic          busy,
    output logic          irq
);

    localparam int unsigned AbortCntW = $clog2(RST_CYC + 1);
    localparam logic [3:0]  AddrCtrl    = 4'h0;
    localparam logic [3:0]  AddrStatus  = 4'h4;
    localparam logic [3:0]  AddrTimeout = 4'h8;
    localparam logic [3:0]  AddrJobCnt  = 4'hC;
    localparam logic [TO_W-1:0]      ToOne   = TO_W'(1);
    localparam logic [AbortCntW-1:0] AbortLast = AbortCntW'(RST_CYC - 1);

    typedef enum logic [2:0] {StIdle, StLaunch, StRun, StFinish, StAbort} state_e;

    state_e               state_q, state_d;
    logic [TO_W-1:0]      run_cnt_q, run_cnt_d;
    logic [TO_W-1:0]      timeout_q, timeout_d;
    logic [CNT_W-1:0]     job_cnt_q, job_cnt_d;
    logic [AbortCntW-1:0] abort_cnt_q, abort_cnt_d;
    logic                 irq_en_q, irq_en_d;
    logic                 done_q, done_d;
    logic                 tmo_q, tmo_d;
    logic                 err_q, err_d;
    logic                 irq_q, irq_d;
    logic                 out_of_rst_q;
    logic [31:0]          rdata_q, rdata_d;
    logic                 rvalid_q, rvalid_d;

    logic        wr_ctrl, wr_status, wr_timeout;
    logic        start_cmd, abort_cmd;
    logic        tmo_hit;
    logic [31:0] rd_val;
    logic        unused_wdata;

    assign unused_wdata = ^bus.reg_wdata;

    assign wr_ctrl    = bus.reg_wr && (bus.reg_addr == AddrCtrl);
    assign wr_status  = bus.reg_wr && (bus.reg_addr == AddrStatus);
    assign wr_timeout = bus.reg_wr && (bus.reg_addr == AddrTimeout);
    assign start_cmd  = wr_ctrl && bus.reg_wdata[0];
    assign abort_cmd  = wr_ctrl && bus.reg_wdata[2];

    // Counter saturates, so a limit lowered below the current count can never match later.
    assign tmo_hit = (state_q == StRun) && (timeout_q != '0) && (run_cnt_q == timeout_q - ToOne);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; in RUN, completion beats timeout, which beats a software abort.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:   if (start_cmd) state_d = StLaunch;
            StLaunch: state_d = StRun;
            StRun: begin
                if (eng_done) begin
                    state_d = StFinish;
                end else if (tmo_hit || abort_cmd) begin
                    state_d = StAbort;
                end
            end
            StFinish: state_d = StIdle;
            StAbort:  if (abort_cnt_q == AbortLast) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // FSM outputs
    always_comb begin
        eng_start = (state_q == StLaunch);
        busy      = (state_q != StIdle);
        eng_rst_n = out_of_rst_q && (state_q != StAbort);
    end

    always_comb begin
        rd_val = '0;
        case (bus.reg_addr)
            AddrCtrl:    rd_val[1] = irq_en_q;
            AddrStatus:  rd_val[3:0] = {err_q, tmo_q, done_q, busy};
            AddrTimeout: rd_val[TO_W-1:0] = timeout_q;
            AddrJobCnt:  rd_val[CNT_W-1:0] = job_cnt_q;
            default:     rd_val = '0;
        endcase
    end

    always_comb begin
        run_cnt_d   = run_cnt_q;
        abort_cnt_d = '0;
        job_cnt_d   = job_cnt_q;
        if (state_q == StLaunch) begin
            run_cnt_d = '0;
        end else if ((state_q == StRun) && (run_cnt_q != '1)) begin
            run_cnt_d = run_cnt_q + ToOne;
        end
        if (state_q == StAbort) begin
            abort_cnt_d = abort_cnt_q + AbortCntW'(1);
        end
        if (state_q == StFinish) begin
            job_cnt_d = job_cnt_q + CNT_W'(1);
        end

        timeout_d = wr_timeout ? bus.reg_wdata[TO_W-1:0] : timeout_q;
        irq_en_d  = wr_ctrl ? bus.reg_wdata[1] : irq_en_q;

        // Hardware set takes precedence over a same-cycle W1C.
        done_d = (done_q && !(wr_status && bus.reg_wdata[1])) || (state_q == StFinish);
        tmo_d  = (tmo_q && !(wr_status && bus.reg_wdata[2])) || (tmo_hit && !eng_done);
        err_d  = (err_q && !(wr_status && bus.reg_wdata[3])) || (start_cmd && busy);

        irq_d    = irq_en_q && (done_q || tmo_q);
        rvalid_d = bus.reg_rd;
        rdata_d  = bus.reg_rd ? rd_val : rdata_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            run_cnt_q    <= '0;
            timeout_q    <= '0;
            job_cnt_q    <= '0;
            abort_cnt_q  <= '0;
            irq_en_q     <= 1'b0;
            done_q       <= 1'b0;
            tmo_q        <= 1'b0;
            err_q        <= 1'b0;
            irq_q        <= 1'b0;
            out_of_rst_q <= 1'b0;
            rdata_q      <= '0;
            rvalid_q     <= 1'b0;
        end else begin
            run_cnt_q    <= run_cnt_d;
            timeout_q    <= timeout_d;
            job_cnt_q    <= job_cnt_d;
            abort_cnt_q  <= abort_cnt_d;
            irq_en_q     <= irq_en_d;
            done_q       <= done_d;
            tmo_q        <= tmo_d;
            err_q        <= err_d;
            irq_q        <= irq_d;
            out_of_rst_q <= 1'b1;
            rdata_q      <= rdata_d;
            rvalid_q     <= rvalid_d;
        end
    end

    assign irq            = irq_q;
    assign bus.reg_rdata  = rdata_q;
    assign bus.reg_rvalid = rvalid_q;

endmodule

// File: tb/tb_img_job_ctrl.sv
// Bench for img_job_ctrl: register vector table plus hand-written job sequences; read data
// is checked against a scoreboard of expected values queued when each read is issued.
module tb_img_job_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic eng_done = 1'b0;
    logic eng_start, eng_rst_n, busy, irq;

    img_job_ctrl_if bus ();

    img_job_ctrl #(
        .TO_W   (16),
        .CNT_W  (4),
        .RST_CYC(2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .eng_start(eng_start),
        .eng_done (eng_done),
        .eng_rst_n(eng_rst_n),
        .busy     (busy),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int start_pulses = 0;
    int ps;
    int exp_jobs;
    string       sb_name[$];
    logic [31:0] sb_exp[$];

    typedef struct packed {
        logic        wr;
        logic        rd;
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs[NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (eng_start === 1'b1) start_pulses++;
        if (bus.reg_rvalid === 1'b1) begin
            if (sb_exp.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_rvalid actual=1 required=0");
            end else begin
                chk(sb_name.pop_front(), bus.reg_rdata, sb_exp.pop_front());
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        bus.reg_wr = 1'b1;
        bus.reg_addr = a;
        bus.reg_wdata = d;
        tick();
        bus.reg_wr = 1'b0;
    endtask

    task automatic rd(input string name, input logic [3:0] a, input logic [31:0] e);
        bus.reg_rd = 1'b1;
        bus.reg_addr = a;
        sb_name.push_back(name);
        sb_exp.push_back(e);
        tick();
        bus.reg_rd = 1'b0;
    endtask

    task automatic quick_job();
        wr(4'h0, 32'h3);
        tick();
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        tick();
    endtask

    initial begin
        bus.reg_wr = 1'b0;
        bus.reg_rd = 1'b0;
        bus.reg_addr = 4'h0;
        bus.reg_wdata = 32'h0;

        vecs[0]  = '{1'b1, 1'b0, 4'h8, 32'hFFFF_FFFF, 32'h0};
        vecs[1]  = '{1'b0, 1'b1, 4'h8, 32'h0,         32'h0000_FFFF};
        vecs[2]  = '{1'b1, 1'b0, 4'h0, 32'h6,         32'h0};
        vecs[3]  = '{1'b0, 1'b1, 4'h0, 32'h0,         32'h2};
        vecs[4]  = '{1'b0, 1'b1, 4'h4, 32'h0,         32'h0};
        vecs[5]  = '{1'b1, 1'b1, 4'h8, 32'h1234,      32'hFFFF};
        vecs[6]  = '{1'b0, 1'b1, 4'h8, 32'h0,         32'h1234};
        vecs[7]  = '{1'b1, 1'b0, 4'hC, 32'hFF,        32'h0};
        vecs[8]  = '{1'b0, 1'b1, 4'hC, 32'h0,         32'h0};
        vecs[9]  = '{1'b0, 1'b1, 4'h2, 32'h0,         32'h0};
        vecs[10] = '{1'b0, 1'b1, 4'hD, 32'h0,         32'h0};
        vecs[11] = '{1'b1, 1'b0, 4'h8, 32'h0,         32'h0};
        vecs[12] = '{1'b0, 1'b1, 4'h8, 32'h0,         32'h0};

        // Reset state
        repeat (3) tick();
        chk("rst_eng_rst_n", 32'(eng_rst_n), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        chk("rst_eng_start", 32'(eng_start), 32'h0);
        chk("rst_rvalid", 32'(bus.reg_rvalid), 32'h0);
        chk("rst_rdata", bus.reg_rdata, 32'h0);
        rst_n = 1'b1;
        tick();
        chk("rst_release_eng_rst_n", 32'(eng_rst_n), 32'h1);

        // Register table
        for (int i = 0; i < NV; i++) begin
            bus.reg_wr = vecs[i].wr;
            bus.reg_rd = vecs[i].rd;
            bus.reg_addr = vecs[i].addr;
            bus.reg_wdata = vecs[i].wdata;
            if (vecs[i].rd) begin
                sb_name.push_back($sformatf("vec%0d", i));
                sb_exp.push_back(vecs[i].exp);
            end
            tick();
        end
        bus.reg_wr = 1'b0;
        bus.reg_rd = 1'b0;
        tick();

        // Normal job: START at cycle 0, eng_done at cycle 790
        ps = start_pulses;
        wr(4'h0, 32'h3);
        chk("job_eng_start_c1", 32'(eng_start), 32'h1);
        chk("job_busy_c1", 32'(busy), 32'h1);
        tick();
        chk("job_eng_start_c2", 32'(eng_start), 32'h0);
        repeat (788) tick();
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        chk("job_busy_finish", 32'(busy), 32'h1);
        chk("job_irq_c791", 32'(irq), 32'h0);
        rd("job_status_c791", 4'h4, 32'h1);
        chk("job_busy_c792", 32'(busy), 32'h0);
        chk("job_irq_c792", 32'(irq), 32'h0);
        rd("job_status_c792", 4'h4, 32'h2);
        chk("job_irq_c793", 32'(irq), 32'h1);
        chk("job_start_pulses", 32'(start_pulses), 32'(ps + 1));
        rd("job_cnt_1", 4'hC, 32'h1);
        wr(4'h4, 32'h2);
        chk("rdata_hold", bus.reg_rdata, 32'h1);
        chk("rvalid_drop", 32'(bus.reg_rvalid), 32'h0);
        tick();
        chk("job_irq_cleared", 32'(irq), 32'h0);
        exp_jobs = 1;

        // Timeout after 100 RUN cycles
        wr(4'h8, 32'd100);
        wr(4'h0, 32'h3);
        repeat (100) tick();
        chk("tmo_rst_n_last_run", 32'(eng_rst_n), 32'h1);
        chk("tmo_busy_last_run", 32'(busy), 32'h1);
        tick();
        chk("tmo_rst_n_low1", 32'(eng_rst_n), 32'h0);
        tick();
        chk("tmo_rst_n_low2", 32'(eng_rst_n), 32'h0);
        tick();
        chk("tmo_rst_n_back", 32'(eng_rst_n), 32'h1);
        chk("tmo_busy_after", 32'(busy), 32'h0);
        rd("tmo_status", 4'h4, 32'h4);
        chk("tmo_irq", 32'(irq), 32'h1);
        rd("tmo_job_cnt", 4'hC, 32'(exp_jobs));
        wr(4'h4, 32'h4);

        // eng_done coinciding with the timeout cycle; W1C DONE during FINISH
        wr(4'h0, 32'h3);
        repeat (100) tick();
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        chk("coin_rst_n_finish", 32'(eng_rst_n), 32'h1);
        wr(4'h4, 32'h2);
        chk("coin_rst_n_idle", 32'(eng_rst_n), 32'h1);
        chk("coin_busy_idle", 32'(busy), 32'h0);
        exp_jobs++;
        rd("coin_status", 4'h4, 32'h2);
        rd("coin_job_cnt", 4'hC, 32'(exp_jobs));
        wr(4'h4, 32'h2);
        wr(4'h8, 32'h0);

        // Busy START sets ERR; software ABORT at RUN cycle 10
        ps = start_pulses;
        wr(4'h0, 32'h3);
        repeat (5) tick();
        wr(4'h0, 32'h3);
        repeat (4) tick();
        wr(4'h0, 32'h6);
        chk("abort_rst_n_low1", 32'(eng_rst_n), 32'h0);
        chk("abort_busy", 32'(busy), 32'h1);
        tick();
        chk("abort_rst_n_low2", 32'(eng_rst_n), 32'h0);
        tick();
        chk("abort_rst_n_back", 32'(eng_rst_n), 32'h1);
        chk("abort_busy_after", 32'(busy), 32'h0);
        chk("abort_start_pulses", 32'(start_pulses), 32'(ps + 1));
        rd("abort_status", 4'h4, 32'h8);
        rd("abort_job_cnt", 4'hC, 32'(exp_jobs));
        wr(4'h4, 32'h8);

        // START and ABORT together in IDLE: START wins
        wr(4'h0, 32'h7);
        chk("sa_eng_start", 32'(eng_start), 32'h1);
        tick();
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        tick();
        exp_jobs++;
        rd("sa_status", 4'h4, 32'h2);
        rd("sa_job_cnt", 4'hC, 32'(exp_jobs));
        wr(4'h4, 32'h2);

        // eng_done outside RUN is ignored
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        rd("idle_done_cnt", 4'hC, 32'(exp_jobs));
        rd("idle_done_status", 4'h4, 32'h0);

        // Job counter wrap (4-bit counter in this bench)
        while (exp_jobs < 15) begin
            quick_job();
            exp_jobs++;
        end
        rd("wrap_cnt_max", 4'hC, 32'hF);
        quick_job();
        exp_jobs = 0;
        rd("wrap_cnt_zero", 4'hC, 32'(exp_jobs));

        // Reset mid-RUN
        wr(4'h8, 32'd50);
        rd("pre_rst_ctrl", 4'h0, 32'h2);
        wr(4'h0, 32'h3);
        repeat (5) tick();
        ps = start_pulses;
        rst_n = 1'b0;
        tick();
        chk("mid_rst_eng_rst_n", 32'(eng_rst_n), 32'h0);
        chk("mid_rst_busy", 32'(busy), 32'h0);
        chk("mid_rst_irq", 32'(irq), 32'h0);
        chk("mid_rst_rdata", bus.reg_rdata, 32'h0);
        rst_n = 1'b1;
        tick();
        chk("mid_rst_release", 32'(eng_rst_n), 32'h1);
        repeat (60) tick();
        chk("mid_rst_no_start", 32'(start_pulses), 32'(ps));
        chk("mid_rst_rst_n_high", 32'(eng_rst_n), 32'h1);
        rd("mid_rst_ctrl", 4'h0, 32'h0);
        rd("mid_rst_status", 4'h4, 32'h0);
        rd("mid_rst_timeout", 4'h8, 32'h0);
        rd("mid_rst_job_cnt", 4'hC, 32'h0);
        repeat (2) tick();
        chk("sb_drained", 32'(sb_exp.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/img_job_ctrl.md
Name: img_job_ctrl

Overview:
- Job sequencer between the PS register bus and one BRAM image-processing engine (e.g. the 28x28 inversion core).
- Software programs a timeout and writes START; the block pulses the engine start, waits for engine completion, and bounds the run with a cycle timeout.
- It reports sticky status, counts completed jobs, raises a level interrupt, and recovers a hung engine with a timed engine reset.

Parameters:
- TO_W, 16, width of timeout limit and run-cycle counter.
- CNT_W, 16, width of completed-job counter.
- RST_CYC, 2, number of cycles eng_rst_n is held low on abort/timeout (>=1).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- reg_wr  in  1  register write strobe, one cycle per access
- reg_rd  in  1  register read strobe, one cycle per access
- reg_addr  in  4  byte address: 0x0 CTRL, 0x4 STATUS, 0x8 TIMEOUT, 0xC JOB_CNT
- reg_wdata  in  32  write data
- reg_rdata  out  32  read data, valid when reg_rvalid
- reg_rvalid  out  1  read data valid, exactly one cycle
- eng_start  out  1  single-cycle engine start pulse
- eng_done  in  1  engine completion pulse
- eng_rst_n  out  1  engine reset, active-low
- busy  out  1  job in progress (state != IDLE)
- irq  out  1  level interrupt

Behaviour:
- Reset (rst_n=0 at clk edge): state IDLE; eng_start=0, eng_rst_n=0, busy=0, irq=0, reg_rvalid=0, reg_rdata=0; CTRL.IRQ_EN=0; STATUS sticky bits=0; TIMEOUT=0; JOB_CNT=0; run counter=0.
  - First cycle after reset release: eng_rst_n=1.
  - Reset mid-job abandons the job silently; no status and no count.
- Registers:
  - CTRL: bit0 START (write-1 command, reads 0); bit1 IRQ_EN (R/W); bit2 ABORT (write-1 command, reads 0).
  - STATUS: bit0 BUSY (RO); bit1 DONE (sticky, W1C); bit2 TMO (sticky, W1C); bit3 ERR (sticky, W1C).
  - TIMEOUT: bits[TO_W-1:0] R/W; upper bits read 0. Value 0 disables the timeout.
  - JOB_CNT: RO, wraps from all-ones to 0; writes ignored.
  - Unmapped bits and addresses read 0.
- Reads: reg_rdata/reg_rvalid registered one cycle after reg_rd. reg_rdata holds its value after reg_rvalid falls.
- reg_wr and reg_rd in the same cycle: both performed. The read returns the pre-write value.
- FSM states IDLE, LAUNCH, RUN, FINISH, ABORT:
  - IDLE: CTRL.START write -> LAUNCH.
  - LAUNCH: eng_start=1 for exactly this cycle; run counter cleared -> RUN.
  - RUN: counter increments each cycle.
    - eng_done=1 -> FINISH.
    - Else, if TIMEOUT!=0 and counter==TIMEOUT-1 -> set TMO, go ABORT.
    - Else, if ABORT written -> ABORT, no TMO.
  - FINISH: set DONE, JOB_CNT+=1 -> IDLE. Total START-write to DONE visible = engine latency + 2 cycles.
  - ABORT: eng_rst_n=0 for RST_CYC cycles -> IDLE. No DONE, no count.
- Priority in RUN when events coincide: eng_done > timeout > ABORT write.
- eng_done outside RUN is ignored.
- START write while busy: ignored; set ERR. START and ABORT written together in IDLE: START wins, ABORT ignored.
- ABORT write in IDLE, LAUNCH or FINISH: ignored.
- W1C on a status bit in the same cycle the FSM sets it: the set wins.
- TIMEOUT writes during RUN take effect immediately. If the new limit is <= current count, the timeout never fires for this job.
- irq = IRQ_EN & (DONE | TMO), registered, one cycle after the cause. Clearing the causes or IRQ_EN drops irq the next cycle.
- busy is high from the cycle after the START write through the last FINISH/ABORT cycle.

Test Plan:
- Normal job: TIMEOUT=0, IRQ_EN=1, START written at cycle 0, eng_done pulsed at cycle 790 -> eng_start high only at cycle 1; DONE=1 at cycle 792; irq=1 at cycle 793; JOB_CNT reads 1; STATUS read = 0x2; W1C 0x2 -> irq=0 next cycle.
- Timeout: TIMEOUT=100, no eng_done -> TMO set after 100 RUN cycles; eng_rst_n low exactly 2 cycles; busy=0 afterwards; JOB_CNT unchanged; DONE=0.
- Coincidence: TIMEOUT=100, eng_done asserted on the 100th RUN cycle -> DONE=1, TMO=0, JOB_CNT+1, eng_rst_n stays 1.
- Software abort / busy start: START, then START again at RUN cycle 5 -> ERR=1, no second eng_start. ABORT written at RUN cycle 10 -> ABORT state, TMO=0, DONE=0.
- Counter wrap and reset: preload via 65535 jobs (or force) -> JOB_CNT wraps to 0. rst_n=0 mid-RUN -> all registers 0, eng_rst_n=0 for that cycle, no eng_start afterwards.
- Register corner cases: write 0xFFFFFFFF to TIMEOUT -> reads 0x0000FFFF. Read 0x0 -> START/ABORT bits read 0. Simultaneous rd/wr of TIMEOUT returns the old value. W1C DONE in the FINISH cycle -> DONE remains 1.
